// File: rtl/eth_frame_tx.sv
// rtl/eth_frame_tx.sv - Ethernet II frame transmitter with RGMII-style DDR nibble output
//
// Builds one frame per accepted start request:
//   7x 55 preamble, D5 SFD, DA, SA, [802.1Q tag], EtherType, 16-bit sequence number,
//   payload read from external block RAM, zero padding up to the 64-byte minimum,
//   CRC-32 FCS (complemented, low byte first), then an inter-frame gap with busy held.
//
// Optional feature macro: ETH_TX_VLAN_EN
//   defined   : 4-byte tag (8100, VLAN_TCI) between SA and EtherType, pad threshold 40
//   undefined : no tag, VLAN_TCI unused, pad threshold 44
//
// Ports:
//   i_clk125     125 MHz byte clock
//   i_rst_n      asynchronous active-low reset
//   i_start      one-cycle frame request, honoured only while o_busy = 0
//   i_start_buf  payload buffer index, sampled with i_start (>= NBUF selects buffer 0)
//   i_len        payload length in bytes, sampled with i_start (clamped to PAYLOAD_MAX)
//   o_busy       high from accepted start through the last IFG cycle
//   o_done       one-cycle pulse on the first IFG cycle
//   o_seq        sequence number the next frame will carry
//   o_rd_addr    {buffer, byte offset} to the payload RAM
//   i_rd_data    payload RAM data, valid one cycle after o_rd_addr
//   o_txctl      RGMII TX_CTL (TX_EN only, TX_ER never asserted)
//   o_txd        RGMII TXD: clock high -> byte[3:0], clock low -> byte[7:4]

module eth_frame_tx #(
    parameter int          PAYLOAD_MAX = 1024,
    parameter int          NBUF        = 2,
    parameter logic [47:0] DST_MAC     = 48'h88dab8bf08,
    parameter logic [47:0] SRC_MAC     = 48'h666666666666,
    parameter logic [15:0] ETHERTYPE   = 16'h1919,
    parameter int          IFG_BYTES   = 12,
    parameter logic [15:0] VLAN_TCI    = 16'h0000,
    localparam int         BUF_W       = (NBUF > 1) ? $clog2(NBUF) : 1,
    localparam int         OFF_W       = $clog2(PAYLOAD_MAX),
    localparam int         LEN_W       = OFF_W + 1
) (
    input  logic                   i_clk125,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [BUF_W-1:0]       i_start_buf,
    input  logic [LEN_W-1:0]       i_len,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [15:0]            o_seq,
    output logic [BUF_W+OFF_W-1:0] o_rd_addr,
    input  logic [7:0]             i_rd_data,
    output logic                   o_txctl,
    output logic [3:0]             o_txd
);

`ifdef ETH_TX_VLAN_EN
    localparam int                  HDR_LEN = 18;
    localparam int                  PAD_MIN = 40;
    localparam logic [HDR_LEN*8-1:0] HDR    = {DST_MAC, SRC_MAC, 16'h8100, VLAN_TCI, ETHERTYPE};
`else
    localparam int                  HDR_LEN = 14;
    localparam int                  PAD_MIN = 44;
    localparam logic [HDR_LEN*8-1:0] HDR    = {DST_MAC, SRC_MAC, ETHERTYPE};

    // VLAN_TCI has no role in the untagged build; folded into a dangling constant.
    logic w_unused_vlan;
    assign w_unused_vlan = ^VLAN_TCI;
`endif

    localparam logic [BUF_W:0] NBUF_EXT = (BUF_W + 1)'(NBUF);

    typedef enum logic [3:0] {
        S_IDLE,
        S_PRE,
        S_SFD,
        S_HDR,
        S_SEQ,
        S_PAY,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t           r_state;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_pad;
    logic [BUF_W-1:0] r_buf;
    logic [OFF_W-1:0] r_off;
    logic [15:0]      r_seq;
    logic [15:0]      r_seq_cap;
    logic [31:0]      r_crc;
    logic [7:0]       r_tx;
    logic             r_txctl;
    logic             r_busy;
    logic             r_done;

    logic [LEN_W-1:0] w_len;
    logic [LEN_W-1:0] w_pad;
    logic [BUF_W-1:0] w_buf;
    logic [7:0]       w_hdr_byte;
    logic [7:0]       w_byte;
    logic             w_off_more;

    // Reflected CRC-32 (poly EDB88320), one byte, LSB first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] x;
        x = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++) begin
            x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
        end
        return x;
    endfunction

    // Request sanitising: oversize lengths clamp, out-of-range buffers fall back to 0.
    always_comb begin
        w_len = (i_len > LEN_W'(PAYLOAD_MAX)) ? LEN_W'(PAYLOAD_MAX) : i_len;
        w_pad = (w_len < LEN_W'(PAD_MIN)) ? (LEN_W'(PAD_MIN) - w_len) : '0;
        w_buf = ({1'b0, i_start_buf} >= NBUF_EXT) ? '0 : i_start_buf;
    end

    always_comb begin
        w_hdr_byte = 8'h00;
        for (int k = 0; k < HDR_LEN; k++) begin
            if (r_cnt == LEN_W'(k)) begin
                w_hdr_byte = HDR[(HDR_LEN-1-k)*8 +: 8];
            end
        end
    end

    // Byte to be loaded into the tx register at the next edge, for the current phase.
    always_comb begin
        w_byte = 8'h00;
        case (r_state)
            S_PRE: w_byte = 8'h55;
            S_SFD: w_byte = 8'hD5;
            S_HDR: w_byte = w_hdr_byte;
            S_SEQ: w_byte = r_cnt[0] ? r_seq_cap[7:0] : r_seq_cap[15:8];
            S_PAY: w_byte = i_rd_data;
            S_FCS: begin
                case (r_cnt[1:0])
                    2'd0:    w_byte = ~r_crc[7:0];
                    2'd1:    w_byte = ~r_crc[15:8];
                    2'd2:    w_byte = ~r_crc[23:16];
                    default: w_byte = ~r_crc[31:24];
                endcase
            end
            default: w_byte = 8'h00;
        endcase
    end

    // RAM is read two edges ahead of the tx register: the address issued on the edge
    // that loads SEQ MSB is consumed on the edge that loads the first payload byte.
    assign w_off_more = ((LEN_W'(r_off) + LEN_W'(1)) < r_len);

    always_ff @(posedge i_clk125 or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_len     <= '0;
            r_pad     <= '0;
            r_buf     <= '0;
            r_off     <= '0;
            r_seq     <= 16'h0000;
            r_seq_cap <= 16'h0000;
            r_crc     <= 32'hFFFF_FFFF;
            r_tx      <= 8'h00;
            r_txctl   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= r_cnt + LEN_W'(1);

            case (r_state)
                S_IDLE: begin
                    r_tx    <= 8'h00;
                    r_txctl <= 1'b0;
                    r_cnt   <= '0;
                    if (i_start) begin
                        r_state   <= S_PRE;
                        r_busy    <= 1'b1;
                        r_len     <= w_len;
                        r_pad     <= w_pad;
                        r_buf     <= w_buf;
                        r_seq_cap <= r_seq;
                        r_crc     <= 32'hFFFF_FFFF;
                    end
                end

                S_PRE: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    if (r_cnt == LEN_W'(6)) begin
                        r_state <= S_SFD;
                        r_cnt   <= '0;
                    end
                end

                S_SFD: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    r_state <= S_HDR;
                    r_cnt   <= '0;
                end

                S_HDR: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    r_crc   <= crc32_byte(r_crc, w_byte);
                    if (r_cnt == LEN_W'(HDR_LEN - 1)) begin
                        r_state <= S_SEQ;
                        r_cnt   <= '0;
                    end
                end

                S_SEQ: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    r_crc   <= crc32_byte(r_crc, w_byte);
                    if (r_cnt == LEN_W'(0)) begin
                        r_off <= '0;
                    end else begin
                        if (w_off_more) begin
                            r_off <= r_off + OFF_W'(1);
                        end
                        r_cnt <= '0;
                        if (r_len != '0) begin
                            r_state <= S_PAY;
                        end else if (r_pad != '0) begin
                            r_state <= S_PAD;
                        end else begin
                            r_state <= S_FCS;
                        end
                    end
                end

                S_PAY: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    r_crc   <= crc32_byte(r_crc, w_byte);
                    if (w_off_more) begin
                        r_off <= r_off + OFF_W'(1);
                    end
                    if (r_cnt == r_len - LEN_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= (r_pad != '0) ? S_PAD : S_FCS;
                    end
                end

                S_PAD: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    r_crc   <= crc32_byte(r_crc, w_byte);
                    if (r_cnt == r_pad - LEN_W'(1)) begin
                        r_cnt   <= '0;
                        r_state <= S_FCS;
                    end
                end

                S_FCS: begin
                    r_tx    <= w_byte;
                    r_txctl <= 1'b1;
                    if (r_cnt == LEN_W'(3)) begin
                        r_cnt   <= '0;
                        r_state <= S_IFG;
                        r_seq   <= r_seq + 16'd1;
                    end
                end

                S_IFG: begin
                    r_tx    <= 8'h00;
                    r_txctl <= 1'b0;
                    r_done  <= (r_cnt == LEN_W'(0));
                    if (r_cnt == LEN_W'(IFG_BYTES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_txctl <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_seq     = r_seq;
    assign o_rd_addr = {r_buf, r_off};
    assign o_txctl   = r_txctl;
    // DDR nibble select on clock level; in silicon this maps onto an output DDR cell.
    assign o_txd     = i_clk125 ? r_tx[3:0] : r_tx[7:4];

endmodule

// File: tb/tb_eth_frame_tx.sv
// tb/tb_eth_frame_tx.sv - table-driven directed bench for eth_frame_tx

module tb_eth_frame_tx;

    localparam int          PAYLOAD_MAX = 1024;
    localparam int          NBUF        = 2;
    localparam int          IFG_BYTES   = 12;
    localparam logic [47:0] DST         = 48'h88dab8bf08;
    localparam logic [47:0] SRC         = 48'h666666666666;
    localparam logic [15:0] ETYPE       = 16'h1919;
    localparam logic [15:0] TCI         = 16'h0064;
`ifdef ETH_TX_VLAN_EN
    localparam int          SEQ_POS     = 26;
    localparam int          PAD_TO      = 40;
`else
    localparam int          SEQ_POS     = 22;
    localparam int          PAD_TO      = 44;
`endif

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        start     = 1'b0;
    logic [0:0]  start_buf = 1'b0;
    logic [10:0] len       = 11'd0;
    logic [7:0]  rd_data   = 8'h00;
    logic        busy;
    logic        done;
    logic [15:0] seq;
    logic [10:0] rd_addr;
    logic        txctl;
    logic [3:0]  txd;

    eth_frame_tx #(
        .PAYLOAD_MAX (PAYLOAD_MAX),
        .NBUF        (NBUF),
        .DST_MAC     (DST),
        .SRC_MAC     (SRC),
        .ETHERTYPE   (ETYPE),
        .IFG_BYTES   (IFG_BYTES),
        .VLAN_TCI    (TCI)
    ) dut (
        .i_clk125    (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .i_start_buf (start_buf),
        .i_len       (len),
        .o_busy      (busy),
        .o_done      (done),
        .o_seq       (seq),
        .o_rd_addr   (rd_addr),
        .i_rd_data   (rd_data),
        .o_txctl     (txctl),
        .o_txd       (txd)
    );

    always #4 clk = ~clk;

    logic [7:0] mem [0:2047];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [15:0] m_seq = 16'h0000;

    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    int first_idx, last_idx, done_idx, idle_idx, addr_buf, addr_off;

    typedef struct {
        int         b;
        int         l;
        bit         poke;
        int         exp_tx;
        int         probe;
        logic [7:0] probe_val;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [31:0] crc_bits(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        logic        fb;
        c = c_in;
        for (int j = 0; j < 8; j++) begin
            fb = c[0] ^ d[j];
            c  = {1'b0, c[31:1]};
            if (fb) c = c ^ 32'hEDB88320;
        end
        return c;
    endfunction

    task automatic build_exp(input int b, input int l, input logic [15:0] s);
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [15:0] et;
        logic [15:0] tci;
        logic [31:0] crc;
        int          pl;
        dmac = DST;
        smac = SRC;
        et   = ETYPE;
        tci  = TCI;
        exp_q.delete();
        pl = (l > PAYLOAD_MAX) ? PAYLOAD_MAX : l;
        for (int i = 0; i < 7; i++) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        for (int i = 5; i >= 0; i--) exp_q.push_back(dmac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) exp_q.push_back(smac[8*i +: 8]);
`ifdef ETH_TX_VLAN_EN
        exp_q.push_back(8'h81);
        exp_q.push_back(8'h00);
        exp_q.push_back(tci[15:8]);
        exp_q.push_back(tci[7:0]);
`else
        if (tci[0] === 1'bx) exp_q.push_back(8'hxx);
`endif
        exp_q.push_back(et[15:8]);
        exp_q.push_back(et[7:0]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        for (int i = 0; i < pl; i++) exp_q.push_back(mem[b*1024 + i]);
        for (int i = pl; i < PAD_TO; i++) exp_q.push_back(8'h00);
        crc = 32'hFFFF_FFFF;
        for (int k = 8; k < exp_q.size(); k++) crc = crc_bits(crc, exp_q[k]);
        crc = ~crc;
        exp_q.push_back(crc[7:0]);
        exp_q.push_back(crc[15:8]);
        exp_q.push_back(crc[23:16]);
        exp_q.push_back(crc[31:24]);
    endtask

    // Starts one frame and captures every txctl byte (low nibble at clk high,
    // high nibble at clk low). Optionally pokes start during the IFG.
    task automatic run_frame(input int b, input int l, input bit poke);
        int         i;
        bit         fin;
        bit         was_tx;
        logic [3:0] lo_n;
        got_q.delete();
        first_idx = -1; last_idx = -1; done_idx = -1; idle_idx = -1;
        addr_buf  = -1; addr_off = -1;
        start_buf = 1'(b);
        len       = 11'(l);
        start     = 1'b1;
        i   = 0;
        fin = 1'b0;
        while (!fin && i < 3000) begin
            @(posedge clk);
            #2;
            if (i == 0) start = 1'b0;
            was_tx = txctl;
            lo_n   = txd;
            if (txctl) begin
                if (first_idx < 0) first_idx = i;
                last_idx = i;
                if (got_q.size() == SEQ_POS && addr_buf < 0) begin
                    addr_buf = int'(rd_addr[10]);
                    addr_off = int'(rd_addr[9:0]);
                end
            end
            if (done && done_idx < 0) done_idx = i;
            if (poke && last_idx >= 0 && !txctl) begin
                if (i == last_idx + 3)             start = 1'b1;
                if (i == last_idx + 4)             start = 1'b0;
                if (i == last_idx + IFG_BYTES - 1) start = 1'b1;
                if (i == last_idx + IFG_BYTES)     start = 1'b0;
            end
            if (!busy && i > 0) begin
                idle_idx = i;
                fin      = 1'b1;
            end
            #4;
            if (was_tx) got_q.push_back({txd, lo_n});
            i++;
        end
        start = 1'b0;
        chk("frame_timeout", fin, 1);
    endtask

    task automatic check_frame(input string tag, input int b, input int l, input int exp_tx);
        int nbad;
        int first_bad;
        build_exp(b, l, m_seq);
        chk({tag, "_txctl_cycles"}, got_q.size(), exp_tx);
        chk({tag, "_start_latency"}, first_idx, 1);
        chk({tag, "_done_cycle"}, done_idx, last_idx + 1);
        chk({tag, "_busy_end"}, idle_idx, last_idx + IFG_BYTES);
        chk({tag, "_seq_hi"}, (got_q.size() > SEQ_POS + 1) ? int'(got_q[SEQ_POS]) : -1, int'(m_seq[15:8]));
        chk({tag, "_seq_lo"}, (got_q.size() > SEQ_POS + 1) ? int'(got_q[SEQ_POS+1]) : -1, int'(m_seq[7:0]));
        chk({tag, "_rd_addr_buf"}, addr_buf, b);
        chk({tag, "_rd_addr_off"}, addr_off, 0);
        nbad      = 0;
        first_bad = -1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k >= got_q.size() || got_q[k] !== exp_q[k]) begin
                nbad++;
                if (first_bad < 0) first_bad = k;
            end
        end
        chk({tag, "_byte_mismatches"}, nbad, 0);
        if (first_bad >= 0 && first_bad < got_q.size())
            chk($sformatf("%s_byte%0d", tag, first_bad), got_q[first_bad], exp_q[first_bad]);
        m_seq = m_seq + 16'd1;
        chk({tag, "_seq_out"}, seq, m_seq);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int q_bad;
        int nb;
        bit hit;

        for (int a = 0; a < 2048; a++) mem[a] = (a >= 1024) ? (8'(a) ^ 8'hA5) : 8'(a);

        // {buf, len, poke IFG, txctl cycles, payload probe offset, probe value}
`ifdef ETH_TX_VLAN_EN
        vecs[0] = '{1,   10, 1'b1,   72,    3, 8'hA6};
        vecs[1] = '{0, 1024, 1'b0, 1056,  300, 8'h2C};
        vecs[2] = '{0,    0, 1'b0,   72,   39, 8'h00};
        vecs[3] = '{0, 2000, 1'b0, 1056, 1023, 8'hFF};
        vecs[4] = '{1,  100, 1'b1,  132,   99, 8'hC6};
        vecs[5] = '{0,   44, 1'b0,   76,   43, 8'h2B};
        vecs[6] = '{0,   45, 1'b0,   77,   44, 8'h2C};
`else
        vecs[0] = '{1,   10, 1'b1,   72,    3, 8'hA6};
        vecs[1] = '{0, 1024, 1'b0, 1052,  300, 8'h2C};
        vecs[2] = '{0,    0, 1'b0,   72,   39, 8'h00};
        vecs[3] = '{0, 2000, 1'b0, 1052, 1023, 8'hFF};
        vecs[4] = '{1,  100, 1'b1,  128,   99, 8'hC6};
        vecs[5] = '{0,   44, 1'b0,   72,   43, 8'h2B};
        vecs[6] = '{0,   45, 1'b0,   73,   44, 8'h2C};
`endif

        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_seq", seq, 0);
        chk("rst_txctl", txctl, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_txd_lo", txd, 0);
        #3;
        chk("rst_txd_hi", txd, 0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].b, vecs[v].l, vecs[v].poke);
            chk($sformatf("v%0d_probe", v),
                (got_q.size() > SEQ_POS + 2 + vecs[v].probe) ? int'(got_q[SEQ_POS + 2 + vecs[v].probe]) : -1,
                int'(vecs[v].probe_val));
            check_frame($sformatf("v%0d", v), vecs[v].b, vecs[v].l, vecs[v].exp_tx);
            if (vecs[v].poke) begin
                q_bad = 0;
                repeat (4) begin
                    @(posedge clk);
                    #2;
                    if (txctl || busy) q_bad++;
                end
                chk($sformatf("v%0d_ifg_start_ignored", v), q_bad, 0);
            end
        end

        // Mid-frame reset at payload byte 100, then a clean frame with seq restarted.
        start_buf = 1'b0;
        len       = 11'd200;
        start     = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        nb  = 0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge clk);
            #2;
            if (txctl) nb++;
            if (nb == SEQ_POS + 103) hit = 1'b1;
        end
        chk("rst_mid_reached", hit, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_txctl", txctl, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_seq", seq, 0);
        chk("rst_mid_rd_addr", rd_addr, 0);
        m_seq = 16'h0000;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_frame(0, 60, 1'b0);
        check_frame("post_rst", 0, 60, SEQ_POS + 2 + 60 + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
